expr_paren_fsm: RTL and testbench

Streaming recogniser for ASCII arithmetic expressions, one character per accepted cycle. Supports multi-digit operands, a configurable operator set and nested parentheses. After every accepted character it reports whether the prefix seen so far is a complete, well-formed expression. It also reports a sticky error flag and the current nesting depth. It sits in the P1 FSM library as the generalised successor of the single-digit alternating digit/operator checker.

---
 rtl/expr_paren_fsm_if.sv | 27 ++
 rtl/expr_paren_fsm.sv | 143 ++++++++++++++
 tb/tb_expr_paren_fsm.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/expr_paren_fsm_if.sv
// Character stream bundle for the expression recogniser.
// Source side drives in/in_valid; recogniser drives out/err/depth.
interface expr_paren_fsm_if #(
  parameter int DEPTH_W = 3
);
  logic [7:0]         in;
  logic               in_valid;
  logic               out;
  logic               err;
  logic [DEPTH_W-1:0] depth;

  modport master (
    output in,
    output in_valid,
    input  out,
    input  err,
    input  depth
  );

  modport slave (
    input  in,
    input  in_valid,
    output out,
    output err,
    output depth
  );
endinterface

// File: rtl/expr_paren_fsm.sv
// Streaming ASCII expression recogniser: multi-digit operands,
// selectable operators, nested parentheses, sticky error.
module expr_paren_fsm #(
  parameter int       MAX_DIGITS = 4,
  parameter int       MAX_DEPTH  = 7,
  parameter int       DEPTH_W    = 3,
  parameter bit [3:0] OPS_MASK   = 4'b1111
) (
  input  logic                clk,
  input  logic                clr,
  expr_paren_fsm_if.slave     bus
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  localparam logic [1:0] S_START  = 2'd0;
  localparam logic [1:0] S_NUM    = 2'd1;
  localparam logic [1:0] S_CLOSED = 2'd2;
  localparam logic [1:0] S_DEAD   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(MAX_DIGITS);
  localparam logic [DEPTH_W-1:0] DEP_MAX =
    DEPTH_W'(MAX_DEPTH);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               out_q, out_d;
  logic               err_q, err_d;

  logic is_digit, is_op, is_open, is_close;

  // Classify the incoming character; disabled operators fall into "other".
  always_comb begin
    is_digit = (bus.in >= 8'h30) && (bus.in <= 8'h39);
    is_op    = (bus.in == 8'h2B && OPS_MASK[0])
             | (bus.in == 8'h2D && OPS_MASK[1])
             | (bus.in == 8'h2A && OPS_MASK[2])
             | (bus.in == 8'h2F && OPS_MASK[3]);
    is_open  = (bus.in == 8'h28);
    is_close = (bus.in == 8'h29);
  end

  // Next-state rules; every illegal transition lands in S_DEAD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    depth_d = depth_q;
    case (state_q)
      S_START: begin
        unique case (1'b1)
          is_digit: begin
            state_d = S_NUM;
            cnt_d   = CNT_W'(1);
          end
          is_open: begin
            if (depth_q < DEP_MAX)
              depth_d = depth_q + 1'b1;
            else
              state_d = S_DEAD;
          end
          default: state_d = S_DEAD;
        endcase
      end
      S_NUM: begin
        unique case (1'b1)
          is_digit: begin
            if (cnt_q < CNT_MAX)
              cnt_d = cnt_q + 1'b1;
            else
              state_d = S_DEAD;
          end
          is_op: begin
            state_d = S_START;
            cnt_d   = '0;
          end
          is_close: begin
            if (depth_q != '0) begin
              depth_d = depth_q - 1'b1;
              state_d = S_CLOSED;
            end else begin
              state_d = S_DEAD;
            end
          end
          default: state_d = S_DEAD;
        endcase
      end
      S_CLOSED: begin
        unique case (1'b1)
          is_op: begin
            state_d = S_START;
            cnt_d   = '0;
          end
          is_close: begin
            if (depth_q != '0)
              depth_d = depth_q - 1'b1;
            else
              state_d = S_DEAD;
          end
          default: state_d = S_DEAD;
        endcase
      end
      S_DEAD: begin
        state_d = S_DEAD;
      end
      default: begin
        state_d = S_START;
        cnt_d   = '0;
        depth_d = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so they register with it.
  always_comb begin
    out_d = ((state_d == S_NUM) || (state_d == S_CLOSED))
          && (depth_d == '0);
    err_d = (state_d == S_DEAD);
  end

  // State and output registers advance only on accepted characters.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_START;
      cnt_q   <= '0;
      depth_q <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (bus.in_valid) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      depth_q <= depth_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.err   = err_q;
  assign bus.depth = depth_q;

endmodule

// File: tb/tb_expr_paren_fsm.sv
// Bench for expr_paren_fsm: directed plan steps plus random streams
// checked against a prefix-rescanning reference model.
module tb_expr_paren_fsm;

  logic clk = 1'b0;
  logic clr = 1'b1;

  always #5 clk = ~clk;

  expr_paren_fsm_if #(.DEPTH_W(3)) ifa ();
  expr_paren_fsm_if #(.DEPTH_W(3)) ifb ();

  expr_paren_fsm #(
    .MAX_DIGITS(4), .MAX_DEPTH(7), .DEPTH_W(3),
    .OPS_MASK(4'b1111)
  ) u_dut_a (.clk(clk), .clr(clr), .bus(ifa.slave));

  expr_paren_fsm #(
    .MAX_DIGITS(4), .MAX_DEPTH(7), .DEPTH_W(3),
    .OPS_MASK(4'b0011)
  ) u_dut_b (.clk(clk), .clr(clr), .bus(ifb.slave));

  int  nvec = 0;
  int  nerr = 0;
  byte q[$];

  // Rescan the whole accepted prefix from scratch using
  // "what may follow what" rules on character classes.
  function automatic void model(
    input  byte        s[$],
    input  logic [3:0] mask,
    output logic       o,
    output logic       e,
    output logic [2:0] d
  );
    int dep = 0;
    int run = 0;
    int prev = 0; // 0 none, 1 digit, 2 op, 3 open, 4 close
    int cls;
    bit ok;
    foreach (s[i]) begin
      byte c = s[i];
      if (c >= "0" && c <= "9") cls = 1;
      else if ((c == "+" && mask[0]) || (c == "-" && mask[1]) ||
               (c == "*" && mask[2]) || (c == "/" && mask[3]))
        cls = 2;
      else if (c == "(") cls = 3;
      else if (c == ")") cls = 4;
      else cls = 5;
      ok = 1'b0;
      case (cls)
        1: begin
          if (prev == 1) begin
            ok = (run < 4);
            run++;
          end else if (prev != 4) begin
            ok = 1'b1;
            run = 1;
          end
        end
        2: ok = (prev == 1 || prev == 4);
        3: ok = (prev == 0 || prev == 2 || prev == 3) && dep < 7;
        4: ok = (prev == 1 || prev == 4) && dep > 0;
        default: ok = 1'b0;
      endcase
      if (!ok) begin
        o = 1'b0;
        e = 1'b1;
        d = 3'(dep);
        return;
      end
      if (cls == 3) dep++;
      if (cls == 4) dep--;
      prev = cls;
    end
    o = (prev == 1 || prev == 4) && dep == 0;
    e = 1'b0;
    d = 3'(dep);
  endfunction

  task automatic chk1(string tag, logic got, logic exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk3(string tag, logic [2:0] got, logic [2:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_models(string tag);
    logic o, e;
    logic [2:0] d;
    model(q, 4'b1111, o, e, d);
    chk1({tag, " a.out"}, ifa.out, o);
    chk1({tag, " a.err"}, ifa.err, e);
    chk3({tag, " a.depth"}, ifa.depth, d);
    model(q, 4'b0011, o, e, d);
    chk1({tag, " b.out"}, ifb.out, o);
    chk1({tag, " b.err"}, ifb.err, e);
    chk3({tag, " b.depth"}, ifb.depth, d);
  endtask

  task automatic step(byte c, bit v, string tag);
    ifa.in = c; ifa.in_valid = v;
    ifb.in = c; ifb.in_valid = v;
    @(posedge clk);
    #1;
    if (v) q.push_back(c);
    check_models(tag);
  endtask

  // Async clear between edges; outputs must drop before the next edge.
  task automatic pulse_clr(string tag);
    #1 clr = 1'b1;
    #1;
    chk1({tag, " clr a.out"}, ifa.out, 1'b0);
    chk1({tag, " clr a.err"}, ifa.err, 1'b0);
    chk3({tag, " clr a.depth"}, ifa.depth, 3'd0);
    chk1({tag, " clr b.err"}, ifb.err, 1'b0);
    clr = 1'b0;
    q.delete();
  endtask

  // Drive a string and compare against literal expected sequences too.
  task automatic dstr(string tag, string s, string eo, string ee,
                      bit use_b);
    pulse_clr(tag);
    for (int i = 0; i < s.len(); i++) begin
      step(s[i], 1'b1, tag);
      if (use_b) begin
        chk1({tag, " lit b.out"}, ifb.out, eo[i] == "1");
        chk1({tag, " lit b.err"}, ifb.err, ee[i] == "1");
      end else begin
        chk1({tag, " lit a.out"}, ifa.out, eo[i] == "1");
        chk1({tag, " lit a.err"}, ifa.err, ee[i] == "1");
      end
    end
  endtask

  string alpha = "0123456789+-*/()x )(";

  initial begin
    ifa.in = 8'h00; ifa.in_valid = 1'b0;
    ifb.in = 8'h00; ifb.in_valid = 1'b0;
    #2;
    chk1("reset a.out", ifa.out, 1'b0);
    chk1("reset a.err", ifa.err, 1'b0);
    chk3("reset a.depth", ifa.depth, 3'd0);
    clr = 1'b0;
    @(negedge clk);
    step("x", 1'b0, "empty");

    dstr("t1", "12+3", "1101", "0000", 1'b0);
    chk3("t1 depth", ifa.depth, 3'd0);
    dstr("t2", "(1+2)*3", "0000101", "0000000", 1'b0);
    dstr("t3", "12345+1", "1111000", "0000111", 1'b0);
    dstr("t4", "((((((((", "00000000", "00000001", 1'b0);
    chk3("t4 depth", ifa.depth, 3'd7);
    dstr("t4b", "1)", "10", "01", 1'b0);
    dstr("t4c", ")", "0", "1", 1'b0);
    dstr("t5", "2*3", "100", "011", 1'b1);
    dstr("t5b", "2-3", "101", "000", 1'b1);
    dstr("t5c", "1", "1", "0", 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("x", 1'b0, "t5 hold");
      chk1("t5 hold out", ifb.out, 1'b1);
      chk1("t5 hold err", ifb.err, 1'b0);
    end
    dstr("t6", "(1+", "000", "000", 1'b0);
    dstr("t6b", "7", "1", "0", 1'b0);

    pulse_clr("rnd");
    for (int i = 0; i < 600; i++) begin
      byte c;
      bit  v;
      c = alpha[$urandom_range(0, alpha.len() - 1)];
      v = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 39) == 0) pulse_clr("rnd");
      step(c, v, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
